// File: rtl/weight_stream_ctrl.sv
// weight_stream_ctrl: streams a (base, length) slice of a 1-cycle-latency weight ROM onto a valid/ready byte stream.
// Optional stall counter output is enabled by defining WEIGHT_STREAM_STALL_CNT_EN.
module weight_stream_ctrl #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH),
  parameter int LEN_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [AW-1:0]    cmd_base,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  output logic [AW-1:0]    rom_addr,
  input  logic [7:0]       rom_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
`ifdef WEIGHT_STREAM_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t           state;
  logic [AW-1:0]    ptr, addr_q;
  logic [LEN_W-1:0] rem;
  logic [1:0][8:0]  mem;
  logic [1:0]       count;
  logic             wp, rp, inflight, inflight_last;
  logic             pop, push, issue, accept, flush;
  logic [2:0]       occ;
  assign cmd_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign out_valid = count != 2'd0;
  assign out_data  = mem[rp][7:0];
  assign out_last  = mem[rp][8];
  assign pop       = out_valid && out_ready;
  assign push      = inflight;
  assign accept    = cmd_valid && state == IDLE;
  assign flush     = abort && state != IDLE;
  // Slots committed for next cycle: held bytes plus the read in flight, minus what leaves now.
  assign occ       = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue     = state == RUN && rem != '0 && occ < 3'd2;
  assign rom_addr  = issue ? ptr : addr_q;
  // Sequencer, address issue, 2-entry output buffer and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      addr_q        <= '0;
      rem           <= '0;
      mem           <= '0;
      count         <= '0;
      wp            <= 1'b0;
      rp            <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      addr_q <= rom_addr;
      done   <= 1'b0;
      if (flush) begin
        state    <= IDLE;
        count    <= '0;
        wp       <= 1'b0;
        rp       <= 1'b0;
        inflight <= 1'b0;
      end else begin
        inflight <= issue;
        if (issue) begin
          inflight_last <= rem == LEN_W'(1);
          ptr           <= ptr == AW'(DEPTH - 1) ? '0 : ptr + 1'b1;
          rem           <= rem - 1'b1;
        end
        if (push) begin
          mem[wp] <= {inflight_last, rom_data};
          wp      <= ~wp;
        end
        if (pop) rp <= ~rp;
        count <= count + {1'b0, push} - {1'b0, pop};
        case (state)
          IDLE: if (accept) begin
            ptr <= cmd_base;
            rem <= cmd_len;
            if (cmd_len != '0) state <= RUN;
            else done <= 1'b1;
          end
          RUN: if (issue && rem == LEN_W'(1)) state <= DRAIN;
          DRAIN: if (pop && out_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
`ifdef WEIGHT_STREAM_STALL_CNT_EN
  // Saturating count of backpressured cycles for the current command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (accept) stall_cnt <= '0;
    else if (busy && out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule

// File: doc/weight_stream_ctrl.md
Name: weight_stream_ctrl

Overview:
- Sequencer that streams a contiguous weight tensor slice out of a synchronous-read weight ROM (1-cycle read latency) onto a valid/ready byte stream.
- Sits between the weight ROM instance and the compute datapath. Turns a (base, length) command into ROM address issue and hides ROM latency behind a 2-entry output buffer.
- Sustains full throughput of 1 byte/cycle and honours downstream backpressure without dropping or duplicating bytes.

Parameters:
- DEPTH, 1024, word count of the attached ROM.
- AW, $clog2(DEPTH), ROM address width.
- LEN_W, AW+1, command length width; allows length == DEPTH.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_base  in  AW  first ROM address.
- cmd_len  in  LEN_W  byte count; 0 is legal.
- abort  in  1  synchronous flush of the current command.
- rom_addr  out  AW  address to ROM.
- rom_data  in  8  ROM data, valid the cycle after the address is sampled.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_data  out  8  stream byte.
- out_last  out  1  marks the final byte of a command.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; cmd_ready=1; rom_addr=0; out_valid=0; out_data=0; out_last=0; busy=0; done=0; buffer empty; in-flight flag cleared.
- States:
  - IDLE: cmd_valid&cmd_ready loads ptr=cmd_base and rem=cmd_len. If cmd_len!=0, go to RUN. If cmd_len==0, stay in IDLE, pulse done next cycle, issue no reads.
  - RUN: issues reads. Goes to DRAIN when rem reaches 0 after the last issue.
  - DRAIN: waits for the buffer and the in-flight read to empty. On the last byte handshake, goes to IDLE and pulses done in the following cycle.
- Issue rule: a read is issued in a cycle when state==RUN, rem>0, and (buffer occupancy + in-flight - pop_this_cycle) < 2.
  - On issue: rom_addr=ptr (combinational from the ptr register), ptr increments, rem decrements, and the in-flight flag is set for the next cycle.
  - rom_addr holds its last value when not issuing.
- Capture: when the in-flight flag is set, rom_data is written into the 2-entry FIFO buffer that same cycle. The last-flag travels with the issue in which rem was 1.
- Output: out_valid = buffer non-empty; out_data/out_last come from the buffer head. A pop occurs when out_valid&out_ready. Simultaneous push and pop is supported at occupancy 1 and at occupancy 2.
- Latency: command accepted at edge E0 → rom_addr=base during the following cycle → ROM samples at E1 → buffer captures at E2 → out_valid high after E2.
- Throughput: with out_ready held high, one byte per cycle with no bubbles after the first.
- Backpressure: while out_ready=0, out_valid/out_data/out_last hold stable. The buffer never overflows; with occupancy 2, no read is issued.
- ptr wrap-around: ptr wraps modulo DEPTH (base+len > DEPTH reads from address 0 onward). This is legal, not an error.
- Simultaneous cmd_valid and done: a command is only accepted once state==IDLE, so a new command can be accepted in the cycle done pulses.
- abort: sampled in RUN/DRAIN. Next edge: state=IDLE, buffer cleared, in-flight read discarded, out_valid=0, no done pulse. abort is ignored in IDLE. abort has priority over a same-cycle pop.
- Reset mid-operation: immediate return to reset values; the in-flight ROM read is discarded.

Optional Feature:
- Macro: WEIGHT_STREAM_STALL_CNT_EN.
- With the macro defined: adds output stall_cnt [31:0].
  - Counts cycles in RUN/DRAIN where out_valid=1 and out_ready=0.
  - Cleared on command accept; saturates at 0xFFFFFFFF; reset value 0.
- Without the macro: no port and no counter logic. All other behaviour is identical.

Test Plan:
- base=0x010, len=4, out_ready=1 → out_data = rom[0x10..0x13] on 4 consecutive cycles. out_valid first high after the 2nd edge from accept. out_last on the 4th byte. done pulses 1 cycle later.
- len=0 → done pulses 1 cycle after accept. rom_addr unchanged, out_valid never asserted, busy stays 0.
- base=0x3FE, len=4, DEPTH=1024 → addresses 0x3FE, 0x3FF, 0x000, 0x001. Bytes in that order.
- len=16, out_ready toggling 1,0,0,1 pattern → all 16 bytes delivered exactly once, in order. Output is stable during stalls; the FIFO never exceeds 2 entries. With the macro defined, stall_cnt equals the number of stall cycles.
- abort asserted after 3 bytes of a len=10 command → out_valid=0 next cycle, no done, cmd_ready=1. A following base=0x100, len=2 command streams rom[0x100], rom[0x101] correctly.
- rst_n pulled low mid-stream for 1 cycle → all outputs return to reset values asynchronously. The next command runs cleanly.
